// File: rtl/gray_step_arbiter_pkg.sv
// Purpose : shared state encoding and requester count for the Gray step arbiter.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package gray_step_arbiter_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gray_step_core.sv
// Purpose : binary step counter with Gray-coded output and a sticky wrap flag.
// Latency : Gray/Ovf update one edge after Clr or Step.
// Backpressure: none; Clr has priority over Step.
// Ports   : Clk, Reset (sync, active-high), Clr, Step -> Gray[GRAY_W], Ovf.
module gray_step_core #(
  parameter int GRAY_W = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clr,
  input  logic              Step,
  output logic [GRAY_W-1:0] Gray,
  output logic              Ovf
);

  logic [GRAY_W-1:0] bin;

  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      bin <= '0;
      Ovf <= 1'b0;
    end else if (Step) begin
      bin <= bin + 1'b1;
      // Stepping from all-ones wraps to zero; the flag stays set until the next Clr.
      if (&bin) Ovf <= 1'b1;
    end
  end

  assign Gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_step_arbiter.sv
// Purpose : round-robin share of one Gray step counter between two requesters;
//           each job clears the counter, issues N steps, returns Gray and wrap flag.
// Latency : grant edge k, Done in cycle k+N, Busy low from edge k+N+1.
// Backpressure: requests are levels held until Done; a losing requester simply waits.
// Ports   : Clk, Reset (sync, active-high), Req[2], Steps0/Steps1[STEP_W] ->
//           Grant[2], Done[2], Result[GRAY_W], Overflow, Busy, Gray[GRAY_W].
module gray_step_arbiter
  import gray_step_arbiter_pkg::*;
#(
  parameter int GRAY_W = 3,
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [NREQ-1:0]   Req,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  output logic [NREQ-1:0]   Grant,
  output logic [NREQ-1:0]   Done,
  output logic [GRAY_W-1:0] Result,
  output logic              Overflow,
  output logic              Busy,
  output logic [GRAY_W-1:0] Gray
);

  state_t            state, state_nxt;
  logic [NREQ-1:0]   grant_q, grant_nxt;
  logic [STEP_W-1:0] remaining, remaining_nxt;
  logic              prio, prio_nxt;
  logic [GRAY_W-1:0] result_q, result_nxt;
  logic              ovf_q, ovf_nxt;
  logic              core_clr, core_step;
  logic              core_ovf;
  logic              pick;

  gray_step_core #(.GRAY_W(GRAY_W)) u_core (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (core_clr),
    .Step  (core_step),
    .Gray  (Gray),
    .Ovf   (core_ovf)
  );

  // Requester chosen in IDLE: the lone requester, or the priority holder on a tie.
  assign pick = (Req == 2'b11) ? prio : Req[1];

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_q;
    remaining_nxt = remaining;
    prio_nxt      = prio;
    result_nxt    = result_q;
    ovf_nxt       = ovf_q;
    core_clr      = 1'b0;
    core_step     = 1'b0;
    case (state)
      IDLE: begin
        if (Req != 2'b00) begin
          grant_nxt     = pick ? 2'b10 : 2'b01;
          remaining_nxt = pick ? Steps1 : Steps0;
          core_clr      = 1'b1;
          // A zero-length job skips RUN and reports straight away.
          state_nxt     = (remaining_nxt != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        core_step     = 1'b1;
        remaining_nxt = remaining - 1'b1;
        if (remaining == STEP_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        grant_nxt  = '0;
        prio_nxt   = ~grant_q[1];
        result_nxt = Gray;
        ovf_nxt    = core_ovf;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      remaining <= '0;
      prio      <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      remaining <= remaining_nxt;
      prio      <= prio_nxt;
      result_q  <= result_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  // During DONE the live counter is already final, so it is shown directly;
  // afterwards the captured copy keeps the last job's outcome visible.
  assign Grant    = grant_q;
  assign Done     = (state == DONE) ? grant_q : '0;
  assign Result   = (state == DONE) ? Gray : result_q;
  assign Overflow = (state == DONE) ? core_ovf : ovf_q;
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Purpose : self-checking bench for gray_step_arbiter (table, corner sequences, random jobs).
// Latency : n/a.
// Backpressure: n/a.
module tb_gray_step_arbiter;

  localparam int GRAY_W = 3;
  localparam int STEP_W = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [1:0]        Req;
  logic [STEP_W-1:0] Steps0, Steps1;
  logic [1:0]        Grant, Done;
  logic [GRAY_W-1:0] Result, Gray;
  logic              Overflow, Busy;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  gray_step_arbiter #(.GRAY_W(GRAY_W), .STEP_W(STEP_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .Steps0   (Steps0),
    .Steps1   (Steps1),
    .Grant    (Grant),
    .Done     (Done),
    .Result   (Result),
    .Overflow (Overflow),
    .Busy     (Busy),
    .Gray     (Gray)
  );

  typedef struct {
    logic [1:0] req;
    int         steps;
    int         owner;
    int         res;
    int         ovf;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: after s steps from zero the binary count is s mod 2^W.
  function automatic int gray_of(input int s);
    int b;
    b = s % (1 << GRAY_W);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Called in an IDLE cycle with Req/Steps already driven; the next edge is the grant edge.
  task automatic run_job(input string nm, input int owner, input int s,
                         input int exp_res, input int exp_ovf,
                         input bit drop, input bit scramble);
    int c;
    tick();
    chk({nm, ".grant"}, Grant, 1 << owner);
    chk({nm, ".busy"}, Busy, 1);
    if (scramble) begin
      if (owner == 0) Steps0 = STEP_W'($urandom);
      else            Steps1 = STEP_W'($urandom);
    end
    c = 0;
    while (Done == 2'b00 && c < 40) begin
      chk({nm, ".gray"}, Gray, gray_of(c));
      tick();
      c++;
    end
    chk({nm, ".done"}, Done, 1 << owner);
    chk({nm, ".latency"}, c, s);
    chk({nm, ".result"}, Result, exp_res);
    chk({nm, ".ovf"}, Overflow, exp_ovf);
    if (drop) Req[owner] = 1'b0;
    tick();
    chk({nm, ".busy_after"}, Busy, 0);
    chk({nm, ".grant_after"}, Grant, 0);
    chk({nm, ".done_after"}, Done, 0);
    chk({nm, ".result_hold"}, Result, exp_res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[7];
    logic [1:0] rq;
    int         sv[2];
    int         own;
    int         mprio;
    bit         keep;

    tbl[0] = '{2'b01, 5,  0, 7, 0};
    tbl[1] = '{2'b10, 9,  1, 1, 1};
    tbl[2] = '{2'b10, 8,  1, 0, 1};
    tbl[3] = '{2'b01, 0,  0, 0, 0};
    tbl[4] = '{2'b10, 7,  1, 4, 0};
    tbl[5] = '{2'b01, 15, 0, 4, 1};
    tbl[6] = '{2'b01, 1,  0, 1, 0};

    Reset = 1'b1; Req = 2'b00; Steps0 = '0; Steps1 = '0;
    tick(); tick();
    chk("reset.grant", Grant, 0);
    chk("reset.done", Done, 0);
    chk("reset.result", Result, 0);
    chk("reset.ovf", Overflow, 0);
    chk("reset.busy", Busy, 0);
    chk("reset.gray", Gray, 0);
    Reset = 1'b0;
    tick();

    // Single-requester jobs from the table.
    for (int i = 0; i < 7; i++) begin
      Req = tbl[i].req;
      if (tbl[i].owner == 0) Steps0 = STEP_W'(tbl[i].steps);
      else                   Steps1 = STEP_W'(tbl[i].steps);
      run_job($sformatf("tbl%0d", i), tbl[i].owner, tbl[i].steps,
              tbl[i].res, tbl[i].ovf, 1'b1, 1'b1);
    end

    // Tie straight after reset: requester 0 first, then requester 1 after one IDLE cycle.
    Reset = 1'b1; tick(); Reset = 1'b0;
    Req = 2'b11; Steps0 = 4'd2; Steps1 = 4'd3;
    run_job("tie0", 0, 2, 3, 0, 1'b1, 1'b0);
    run_job("tie1", 1, 3, 2, 0, 1'b1, 1'b0);

    // Both held high with one-step jobs: ownership alternates.
    Req = 2'b11; Steps0 = 4'd1; Steps1 = 4'd1;
    for (int i = 0; i < 4; i++)
      run_job($sformatf("alt%0d", i), i % 2, 1, 1, 0, 1'b0, 1'b0);
    Req = 2'b00;
    tick();

    // Reset in the middle of a job drops it silently.
    Req = 2'b01; Steps0 = 4'd6;
    tick();
    chk("midrst.grant", Grant, 1);
    tick(); tick(); tick();
    chk("midrst.gray3", Gray, gray_of(3));
    Reset = 1'b1; Req = 2'b00;
    tick();
    chk("midrst.grant0", Grant, 0);
    chk("midrst.busy0", Busy, 0);
    chk("midrst.gray0", Gray, 0);
    chk("midrst.done0", Done, 0);
    chk("midrst.result0", Result, 0);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst.nodone", Done, 0);
    end
    Req = 2'b10; Steps1 = 4'd4;
    run_job("post_rst", 1, 4, gray_of(4), 0, 1'b1, 1'b1);

    // Random traffic against a job-level model (round-robin owner, steps-derived result).
    Reset = 1'b1; Req = 2'b00; tick(); Reset = 1'b0;
    rq = 2'b00; mprio = 0; sv[0] = 0; sv[1] = 0;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] && $urandom_range(1, 0) == 1) begin
          rq[i] = 1'b1;
          sv[i] = $urandom_range(15, 0);
        end
      end
      if (rq == 2'b00) begin
        own = $urandom_range(1, 0);
        rq[own] = 1'b1;
        sv[own] = $urandom_range(15, 0);
      end
      Req = rq; Steps0 = STEP_W'(sv[0]); Steps1 = STEP_W'(sv[1]);
      own  = (rq == 2'b11) ? mprio : (rq[1] ? 1 : 0);
      keep = ($urandom_range(3, 0) == 0);
      run_job($sformatf("rand%0d", j), own, sv[own], gray_of(sv[own]),
              (sv[own] >= 8) ? 1 : 0, !keep, 1'b1);
      mprio = 1 - own;
      if (keep) sv[own] = $urandom_range(15, 0);
      else      rq[own] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
